// File: rtl/thumb_inst_align.sv
// Thumb halfword-to-instruction aligner: a circular halfword FIFO that emits 16-bit or 32-bit Thumb-2 instructions.
// Optional issue counter on inst_cnt is enabled by defining THUMB_INST_ALIGN_CNT_EN.
module thumb_inst_align #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [15:0] hw_in,
  input  logic        hw_valid,
  output logic        hw_ready,
  output logic [31:0] inst,
  output logic        inst_is32,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (FIFO_DEPTH != 4 && FIFO_DEPTH != 8) begin : g_bad_depth
      $error("thumb_inst_align: FIFO_DEPTH must be 4 or 8");
    end
  endgenerate

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [15:0]      head;
  logic [15:0]      second;
  logic             head_is32;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] pop_size;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    second    = mem_q[rd_ptr_q + PTR_W'(1)];
    // 11101, 11110, 11111 in [15:11] mark the first half of a 32-bit encoding
    head_is32 = (head[15:13] == 3'b111) && (head[12:11] != 2'b00);

    hw_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    inst_valid = head_is32 ? (count_q >= CNT_W'(2)) : (count_q != '0);

    inst      = 32'h0;
    inst_is32 = 1'b0;
    if (inst_valid) begin
      inst      = head_is32 ? {head, second} : {head, 16'h0};
      inst_is32 = head_is32;
    end

    push     = hw_valid && hw_ready && !flush;
    pop      = inst_valid && inst_ready && !flush;
    pop_size = pop ? (head_is32 ? CNT_W'(2) : CNT_W'(1)) : '0;
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = hw_in;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_size);
      count_d  = count_q + CNT_W'(push) - pop_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef THUMB_INST_ALIGN_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 32'h0;
    else     cnt_q <= cnt_d;
  end

  assign inst_cnt = cnt_q;
`else
  assign inst_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_thumb_inst_align.sv
// Directed vector table plus reference-queue stream checks for thumb_inst_align (FIFO_DEPTH = 4).
module tb_thumb_inst_align;

  logic        clk = 1'b0;
  logic        rst, flush, hw_valid, inst_ready;
  logic [15:0] hw_in;
  logic        hw_ready, inst_is32, inst_valid;
  logic [31:0] inst, inst_cnt;

  thumb_inst_align #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hw_in(hw_in), .hw_valid(hw_valid),
    .hw_ready(hw_ready), .inst(inst), .inst_is32(inst_is32), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, hv;
    logic [15:0] hin;
    logic        ir, e_hr, e_iv;
    logic [31:0] e_inst;
    logic        e_is32;
  } vec_t;

  vec_t vq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned pops   = 0;
  logic [15:0] stream [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef THUMB_INST_ALIGN_CNT_EN
    return pops;
`else
    return 32'h0;
`endif
  endfunction

  function automatic bit is_pre(input logic [15:0] h);
    return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
  endfunction

  task automatic addv(input logic r, input logic f, input logic hv, input logic [15:0] hin,
                      input logic ir, input logic e_hr, input logic e_iv,
                      input logic [31:0] e_inst, input logic e_is32);
    vec_t v;
    v.rst = r; v.flush = f; v.hv = hv; v.hin = hin; v.ir = ir;
    v.e_hr = e_hr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_is32 = e_is32;
    vq.push_back(v);
  endtask

  task automatic run_stream(input bit throttle, input string tag);
    logic [15:0] q[$];
    int  idx = 0;
    bit  done = 0;
    bit  e_hr, e_iv, e_is32;
    logic [31:0] e_inst;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      rst = 0; flush = 0;
      hw_valid   = (idx < 20);
      hw_in      = (idx < 20) ? stream[idx] : 16'h0;
      inst_ready = throttle ? (cyc % 3 == 2) : 1'b1;
      e_hr = (q.size() < 4);
      e_iv = 0; e_is32 = 0; e_inst = 32'h0;
      if (q.size() >= 1 && !is_pre(q[0])) begin
        e_iv = 1; e_inst = {q[0], 16'h0};
      end else if (q.size() >= 2 && is_pre(q[0])) begin
        e_iv = 1; e_is32 = 1; e_inst = {q[0], q[1]};
      end
      @(negedge clk);
      chk($sformatf("%s c%0d hw_ready", tag, cyc), {31'b0, hw_ready}, {31'b0, e_hr});
      chk($sformatf("%s c%0d inst_valid", tag, cyc), {31'b0, inst_valid}, {31'b0, e_iv});
      chk($sformatf("%s c%0d inst", tag, cyc), inst, e_inst);
      chk($sformatf("%s c%0d inst_is32", tag, cyc), {31'b0, inst_is32}, {31'b0, e_is32});
      chk($sformatf("%s c%0d inst_cnt", tag, cyc), inst_cnt, exp_cnt());
      @(posedge clk);
      if (e_iv && inst_ready) begin
        void'(q.pop_front());
        if (e_is32) void'(q.pop_front());
        pops++;
      end
      if (hw_valid && e_hr) begin
        q.push_back(hw_in);
        idx++;
      end
      #1;
      if (idx == 20 && q.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain: got idx %0d left %0d expected all 20 issued", tag, idx, q.size());
    end
  endtask

  initial begin
    stream = '{16'hBF00, 16'hF000, 16'hB800, 16'h2001, 16'hE92D, 16'h4FF0, 16'hF7FF, 16'hFFFE,
               16'h4770, 16'h2002, 16'hF8D0, 16'h1234, 16'h3003, 16'hE800, 16'h0001, 16'hFA00,
               16'hF000, 16'h4400, 16'hF3AF, 16'h8000};

    //   rst flush hv  hin      ir hr iv inst          is32
    addv(0, 0, 0, 16'h0000, 0, 1, 0, 32'h00000000, 0);  // post-reset outputs
    addv(0, 0, 1, 16'hBF08, 1, 1, 0, 32'h00000000, 0);  // 16-bit stream
    addv(0, 0, 1, 16'h2001, 1, 1, 1, 32'hBF080000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h20010000, 0);
    addv(0, 0, 1, 16'hF000, 1, 1, 0, 32'h00000000, 0);  // split 32-bit
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'hB800, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'hF000B800, 1);
    addv(0, 0, 0, 16'h0000, 0, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'h1111, 0, 1, 0, 32'h00000000, 0);  // fill under backpressure
    addv(0, 0, 1, 16'h2222, 0, 1, 1, 32'h11110000, 0);
    addv(0, 0, 1, 16'h3333, 0, 1, 1, 32'h11110000, 0);
    addv(0, 0, 1, 16'h4444, 0, 1, 1, 32'h11110000, 0);
    addv(0, 0, 1, 16'h5555, 0, 0, 1, 32'h11110000, 0);  // full: 5th refused
    addv(0, 0, 0, 16'h0000, 1, 0, 1, 32'h11110000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h22220000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h33330000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h44440000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'hE800, 0, 1, 0, 32'h00000000, 0);  // flush with 3 buffered
    addv(0, 0, 1, 16'h0001, 0, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'h1234, 0, 1, 1, 32'hE8000001, 1);
    addv(0, 1, 1, 16'hABCD, 0, 1, 1, 32'hE8000001, 1);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'h2AAA, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h2AAA0000, 0);
    addv(0, 0, 1, 16'hE92D, 1, 1, 0, 32'h00000000, 0);  // reset with lone prefix
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(1, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 1, 16'h4770, 1, 1, 0, 32'h00000000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 1, 32'h47700000, 0);
    addv(0, 0, 0, 16'h0000, 1, 1, 0, 32'h00000000, 0);

    rst = 1; flush = 0; hw_valid = 0; hw_in = 16'h0; inst_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    pops = 0;

    foreach (vq[i]) begin
      rst = vq[i].rst; flush = vq[i].flush; hw_valid = vq[i].hv;
      hw_in = vq[i].hin; inst_ready = vq[i].ir;
      @(negedge clk);
      chk($sformatf("v%0d hw_ready", i), {31'b0, hw_ready}, {31'b0, vq[i].e_hr});
      chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vq[i].e_iv});
      chk($sformatf("v%0d inst", i), inst, vq[i].e_inst);
      chk($sformatf("v%0d inst_is32", i), {31'b0, inst_is32}, {31'b0, vq[i].e_is32});
      chk($sformatf("v%0d inst_cnt", i), inst_cnt, exp_cnt());
      @(posedge clk);
      if (vq[i].rst) pops = 0;
      else if (!vq[i].flush && vq[i].e_iv && vq[i].ir) pops++;
      #1;
    end

    run_stream(1'b0, "stream");
    run_stream(1'b1, "throttled");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thumb_inst_align.md
THUMB_INST_ALIGN -- requirements
Module: thumb_inst_align

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, halfword buffer depth; legal values 4 or 8 only.
REQ-002 The block SHALL have a single clock domain with a synchronous, active-high reset. It SHALL provide the following ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all buffered halfwords (branch/exception redirect).
- hw_in  input  16  instruction halfword from instruction memory.
- hw_valid  input  1  hw_in carries a valid halfword.
- hw_ready  output  1  buffer can accept a halfword this cycle.
- inst  output  32  aligned instruction; first halfword in [31:16]; for a 16-bit instruction, [15:0] = 0.
- inst_is32  output  1  inst is a 32-bit Thumb-2 encoding.
- inst_valid  output  1  inst/inst_is32 valid this cycle.
- inst_ready  input  1  downstream decode accepts inst this cycle.
- inst_cnt  output  32  count of issued instructions (see Configuration).

Function
REQ-003 Storage SHALL be a circular halfword FIFO with a read pointer, a write pointer and an occupancy count of 0..FIFO_DEPTH. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-004 A push SHALL occur when hw_valid and hw_ready are both 1 and flush is 0.
REQ-005 hw_ready SHALL be 1 when count < FIFO_DEPTH, and 0 otherwise. The full state is (count == FIFO_DEPTH); while full, hw_in SHALL be ignored.
REQ-006 A head halfword SHALL be classified as a 32-bit prefix when its bits [15:11] are 11101, 11110 or 11111. Otherwise it is a 16-bit instruction.
REQ-007 inst_valid SHALL be 1 in either of these cases; otherwise it SHALL be 0:
- count >= 1 and the head is a 16-bit instruction;
- count >= 2 and the head is a 32-bit prefix.
REQ-008 When inst_valid is 1, the outputs SHALL be driven as follows. When inst_valid is 0, inst SHALL be 32'h0 and inst_is32 SHALL be 0.
- 16-bit head: inst = {head, 16'h0}.
- 32-bit prefix: inst = {head, head+1}.
REQ-009 A pop SHALL occur when inst_valid and inst_ready are both 1. The pop SHALL advance the read pointer by 1 for a 16-bit instruction and by 2 for a 32-bit instruction.
REQ-010 A push and a pop in the same cycle SHALL both take effect: count_next = count + push - popsize.
REQ-011 Latency: a halfword pushed at rising edge N SHALL be presentable on inst in the cycle following edge N. The output path from storage to inst is combinational.
REQ-012 A 32-bit prefix held with count == 1 SHALL keep inst_valid at 0 until the second halfword is pushed. The prefix SHALL NOT be issued alone.
REQ-013 When flush is 1 at a rising edge, the block SHALL clear:
- count,
- the read and write pointers.

Flush SHALL take priority over a simultaneous push and pop. inst_valid SHALL be 0 in the following cycle.
REQ-014 The block SHALL NOT drop, duplicate or reorder halfwords under any interleaving of hw_valid and inst_ready.

Reset
REQ-015 When rst is 1 at a rising edge, the block SHALL clear count, the pointers and inst_cnt to 0.
REQ-016 In the cycle after reset, the outputs SHALL be: hw_ready = 1, inst_valid = 0, inst = 32'h0, inst_is32 = 0.
REQ-017 rst SHALL take priority over flush, push and pop. A reset asserted while a 32-bit instruction is half-buffered SHALL discard that halfword.

Configuration
REQ-018 With macro THUMB_INST_ALIGN_CNT_EN defined, inst_cnt SHALL increment by 1 on every pop. It SHALL wrap from 32'hFFFFFFFF to 0, and it SHALL be unaffected by flush.
REQ-019 Without THUMB_INST_ALIGN_CNT_EN, inst_cnt SHALL be tied to 32'h0 and no counter logic SHALL be instantiated.

Verification
REQ-020 Scenario, 16-bit stream: push 16'hBF08 then 16'h2001, with inst_ready = 1.
- Expected: inst = 32'hBF080000 with inst_is32 = 0, then inst = 32'h20010000.
- With THUMB_INST_ALIGN_CNT_EN defined, inst_cnt = 2.
REQ-021 Scenario, 32-bit split: push 16'hF000, idle 3 cycles, then push 16'hB800.
- Expected: inst_valid stays 0 during the idle cycles.
- Expected: inst = 32'hF000B800 with inst_is32 = 1, exactly one cycle after the second push.
REQ-022 Scenario, full/backpressure: hold inst_ready = 0 and push 5 halfwords with FIFO_DEPTH = 4.
- Expected: hw_ready drops to 0 after the 4th push, and the 5th halfword is not accepted.
- Release inst_ready. Expected: the first four halfwords emerge in order.
REQ-023 Scenario, wrap-around with simultaneous push/pop: stream 20 mixed 16/32-bit halfwords with hw_valid = 1 and inst_ready = 1.
- Expected: the output sequence matches a reference model.
- Expected: count never exceeds 4.
REQ-024 Scenario, flush: with 3 halfwords buffered, assert flush together with hw_valid.
- Expected: the next cycle has inst_valid = 0 and hw_ready = 1, and the halfword presented with flush is not stored.
REQ-025 Scenario, reset mid-operation: assert rst with a lone 32-bit prefix 16'hE92D buffered.
- Expected: after reset, push 16'h4770 yields inst = 32'h47700000 with inst_is32 = 0, and inst_cnt = 0 before that pop.
